// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display controller:
// the hex decode table (active-low gfedcba), the blank pattern and the digit index type.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed table indexed by nibble value; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // D
    7'b1000110,  // C
    7'b0000011,  // B
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder (active-low {g,f,e,d,c,b,a}).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Four-digit multiplexed seven-segment display controller with frame-synchronous value updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        boardclk,
  input  logic        rst,
  input  logic [15:0] disp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count_q, count_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   shownVal_q, shownVal_d;
  logic [15:0]   pendVal_q, pendVal_d;
  logic          pendFlag_q, pendFlag_d;
  logic          tick;
  logic          frameWrap;
  logic [3:0]    nibble;
  logic [6:0]    decoded;

  assign tick      = (count_q == COUNT_MAX);
  assign frameWrap = tick && (idx_q == 2'd3);

  // The displayed value only moves at a frame boundary, so a frame never mixes two values;
  // a load landing exactly on the wrap takes priority over an older pending value.
  always_comb begin
    count_d    = tick ? '0 : count_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    pendVal_d  = load ? disp_in : pendVal_q;
    pendFlag_d = load ? 1'b1 : pendFlag_q;
    shownVal_d = shownVal_q;
    if (frameWrap) begin
      pendFlag_d = 1'b0;
      if (load) begin
        shownVal_d = disp_in;
      end else if (pendFlag_q) begin
        shownVal_d = pendVal_q;
      end
    end
  end

  always_ff @(posedge boardclk) begin
    if (!rst) begin
      count_q    <= '0;
      idx_q      <= 2'd0;
      shownVal_q <= 16'h0000;
      pendVal_q  <= 16'h0000;
      pendFlag_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      idx_q      <= idx_d;
      shownVal_q <= shownVal_d;
      pendVal_q  <= pendVal_d;
      pendFlag_q <= pendFlag_d;
    end
  end

  assign nibble = shownVal_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hexToSeg7 (
    .nibble_i (nibble),
    .seg_o    (decoded)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic blank;

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (shownVal_q[15:4] == 12'h000);
      2'd2:    blank = (shownVal_q[15:8] == 8'h00);
      2'd3:    blank = (shownVal_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end

  assign seg = blank ? SEG_BLANK : decoded;
`else
  assign seg = decoded;
`endif

  assign an         = ~(4'b0001 << idx_q);
  assign dp         = 1'b1;
  assign frame_done = frameWrap;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Directed bench for seg7_disp_ctrl with REFRESH_DIV=4 (16 cycles per frame).
// Expected segment patterns are hand-written; leading-zero digits follow SEG7_LZ_BLANK_EN.
module tb_seg7_disp_ctrl;

  logic        boardclk;
  logic        rst;
  logic [15:0] disp_in;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] DA = 7'b0001000;
  localparam logic [6:0] DB = 7'b0000011;
  localparam logic [6:0] DC = 7'b1000110;
  localparam logic [6:0] DD = 7'b0100001;
  localparam logic [6:0] DE = 7'b0000110;
  localparam logic [6:0] DF = 7'b0001110;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  localparam logic [3:0][6:0] ZERO_FRAME = {LZ, LZ, LZ, D0};

  typedef struct {
    logic [15:0]     value;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] anTab [4];

  seg7_disp_ctrl #(.REFRESH_DIV(4)) dut (
    .boardclk   (boardclk),
    .rst        (rst),
    .disp_in    (disp_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial boardclk = 1'b0;
  always #5 boardclk = ~boardclk;

  task automatic stepCycle();
    @(posedge boardclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Runs one full frame from slot 0, checking every cycle and optionally loading at up to two cycles.
  task automatic applyStimulus(input string tag, input logic [3:0][6:0] expSeg,
                               input int ldA, input logic [15:0] valA,
                               input int ldB, input logic [15:0] valB);
    for (int k = 0; k < 16; k++) begin
      int slot;
      slot = k / 4;
      checkOutput($sformatf("%s an k=%0d", tag, k), {12'h000, an}, {12'h000, anTab[slot]});
      checkOutput($sformatf("%s seg k=%0d", tag, k), {9'h000, seg}, {9'h000, expSeg[slot]});
      checkOutput($sformatf("%s frame_done k=%0d", tag, k), {15'h0000, frame_done}, {15'h0000, (k == 15)});
      if (k == 0) checkOutput($sformatf("%s dp", tag), {15'h0000, dp}, 16'h0001);
      load    = (k == ldA) || (k == ldB);
      disp_in = (k == ldA) ? valA : ((k == ldB) ? valB : 16'hDEAD);
      stepCycle();
      load    = 1'b0;
      disp_in = 16'hDEAD;
    end
  endtask

  initial begin
    logic [3:0][6:0] prevExp;

    anTab[0] = 4'b1110;
    anTab[1] = 4'b1101;
    anTab[2] = 4'b1011;
    anTab[3] = 4'b0111;

    vecs[0] = '{16'h3210, {D3, D2, D1, D0}};
    vecs[1] = '{16'h7654, {D7, D6, D5, D4}};
    vecs[2] = '{16'hBA98, {DB, DA, D9, D8}};
    vecs[3] = '{16'hFEDC, {DF, DE, DD, DC}};
    vecs[4] = '{16'h0042, {LZ, LZ, D4, D2}};
    vecs[5] = '{16'h0100, {LZ, D1, D0, D0}};
    vecs[6] = '{16'h0000, {LZ, LZ, LZ, D0}};

    // Reset with a load held active: the load must be ignored.
    rst     = 1'b0;
    load    = 1'b1;
    disp_in = 16'hFFFF;
    repeat (10) stepCycle();
    checkOutput("reset an", {12'h000, an}, 16'h000E);
    checkOutput("reset seg", {9'h000, seg}, 16'h0040);
    checkOutput("reset dp", {15'h0000, dp}, 16'h0001);
    checkOutput("reset frame_done", {15'h0000, frame_done}, 16'h0000);
    rst     = 1'b1;
    load    = 1'b0;
    disp_in = 16'h0000;

    applyStimulus("load1234", ZERO_FRAME, 5, 16'h1234, -1, 16'h0000);
    applyStimulus("loadOnWrap", {D1, D2, D3, D4}, 2, 16'h1111, 15, 16'hBEEF);
    applyStimulus("lastWins", {DB, DE, DE, DF}, 3, 16'hAAAA, 9, 16'h5555);
    applyStimulus("show5555", {D5, D5, D5, D5}, -1, 16'h0000, -1, 16'h0000);
    prevExp = {D5, D5, D5, D5};

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), prevExp, 6, vecs[i].value, -1, 16'h0000);
      prevExp = vecs[i].segs;
    end
    applyStimulus("vecLast", prevExp, 4, 16'h1234, -1, 16'h0000);

    // Mid-frame reset at digit 2 with a pending load that must never appear.
    for (int k = 0; k < 8; k++) begin
      load    = (k == 2);
      disp_in = (k == 2) ? 16'h9999 : 16'hDEAD;
      stepCycle();
      load    = 1'b0;
    end
    checkOutput("preReset an", {12'h000, an}, 16'h000B);
    checkOutput("preReset seg", {9'h000, seg}, {9'h000, D2});
    rst = 1'b0;
    stepCycle();
    checkOutput("midReset an", {12'h000, an}, 16'h000E);
    checkOutput("midReset seg", {9'h000, seg}, 16'h0040);
    checkOutput("midReset frame_done", {15'h0000, frame_done}, 16'h0000);
    rst = 1'b1;
    applyStimulus("postReset0", ZERO_FRAME, -1, 16'h0000, -1, 16'h0000);
    applyStimulus("postReset1", ZERO_FRAME, -1, 16'h0000, -1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/seg7_disp_ctrl.md
SEG7_DISP_CTRL -- requirements
Module: seg7_disp_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, boardclk cycles per digit slot; legal range >= 2.
REQ-002 boardclk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 disp_in  input  16  display value from the processor's disp output.
REQ-005 load  input  1  capture strobe for disp_in; level-sampled every cycle.
REQ-006 an  output  4  digit enables, active-low one-hot; an[0] = rightmost digit.
REQ-007 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  output  1  decimal point, active-low; held 1 (off).
REQ-009 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1, wrapping to 0; tick = (count == REFRESH_DIV-1).
REQ-011 Digit index idx (2 bits) SHALL increment on tick, wrapping 3 -> 0.
REQ-012 Frame wrap = tick while idx == 3; frame_done SHALL be 1 in exactly that cycle, else 0.
REQ-013 load=1 SHALL write disp_in to pend_val and set pend_flag; multiple loads within one frame: last wins.
REQ-014 On frame wrap: if load=1 that cycle, shown_val <= disp_in; else if pend_flag, shown_val <= pend_val; pend_flag cleared in both cases.
REQ-015 shown_val SHALL change only on frame wrap (no tearing within a frame).
REQ-016 an = ~(4'b0001 << idx); nibble = shown_val[4*idx+3 : 4*idx].
REQ-017 seg SHALL be the combinational hex decode of the selected nibble; an/seg change the cycle after the edge that updates idx/shown_val, with no further latency.
REQ-018 Decode table (gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 B=0000011 C=1000110 D=0100001 E=0000110 F=0001110.

Reset
REQ-019 With rst=0 at a rising edge: count=0, idx=0, shown_val=0, pend_val=0, pend_flag=0.
REQ-020 Outputs during/after reset: an=4'b1110, seg=7'b1000000, dp=1, frame_done=0.
REQ-021 Reset mid-frame SHALL discard any pending load; load asserted during reset SHALL be ignored.

Configuration
REQ-022 Macro SEG7_LZ_BLANK_EN: when defined, digits above the most significant nonzero nibble SHALL output seg=7'b1111111; digit 0 never blanked (value 0 shows a single "0").
REQ-023 Without SEG7_LZ_BLANK_EN, all four digits SHALL always show their decoded nibble.
REQ-024 Blanking is evaluated from shown_val only; an timing is unchanged by the macro.

Structure
REQ-025 Package seg7_pkg SHALL hold the 16-entry decode constants, SEG_BLANK (7'b1111111), and the digit-index typedef.
REQ-026 Sub-module hex_to_seg7 (4-bit in, 7-bit out, combinational) SHALL implement REQ-018; the top instantiates it once.

Verification (REFRESH_DIV=4)
REQ-027 Hold rst=0 for 10 cycles, release, disp_in=0 -> an=1110, seg=1000000; 4 cycles later an=1101; frame_done pulses at cycle 16.
REQ-028 load 16'h1234 at cycle 5 -> seg unchanged until frame_done; next frame slots 0..3 show 0011001, 0110000, 0100100, 1111001.
REQ-029 load 16'hBEEF in exactly the frame_done cycle, with an earlier load 16'h1111 in that frame -> next frame shows F,E,E,B (0001110, 0000110, 0000110, 0000011).
REQ-030 loads 16'hAAAA then 16'h5555 in one frame -> next frame shows 5 on all digits.
REQ-031 rst=0 pulse while idx=2 with a pending load -> an=1110, seg=1000000, pending value never displayed.
REQ-032 shown_val=16'h0042 -> with SEG7_LZ_BLANK_EN, digits 3,2 seg=1111111; without it, seg=1000000.
